// File: rtl/ccsds123_stream_monitor_if.sv
// ccsds123_stream_monitor_if: snooped core handshakes plus the statistics record stream
interface ccsds123_stream_monitor_if #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
);
  logic                   in_tvalid;
  logic                   in_tready;
  logic                   out_tvalid;
  logic                   out_tlast;
  logic [IDX_W+4*CNT_W:0] stat_tdata;
  logic                   stat_tvalid;
  logic                   stat_tready;
  modport master (
    output in_tvalid, in_tready, out_tvalid, out_tlast, stat_tready,
    input  stat_tdata, stat_tvalid
  );
  modport slave (
    input  in_tvalid, in_tready, out_tvalid, out_tlast, stat_tready,
    output stat_tdata, stat_tvalid
  );
endinterface

// File: rtl/ccsds123_stream_monitor.sv
// ccsds123_stream_monitor: per-frame cycle statistics of the ccsds123 streams; optional CCSDS123_MON_WATCHDOG_EN
module ccsds123_stream_monitor #(
  parameter int PIPELINES = 4,
  parameter int CNT_W     = 32,
  parameter int IDX_W     = 16,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic clk,
  input  logic rst,
  ccsds123_stream_monitor_if.slave s,
  output logic busy,
  output logic dropped
);
  localparam int DW = IDX_W + 4*CNT_W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX = '1;
  if (PIPELINES < 1 || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0 || TIMEOUT < 2) begin : g_bad
    $error("ccsds123_stream_monitor: bad parameters");
  end
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [CNT_W-1:0] total, stalled, beats, ovalid;
  logic [CNT_W-1:0] n_total, n_stalled, n_beats, n_ovalid;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt, cnt_n;
  logic start, fin, to, push, push_ok, pop, full;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v, input logic b);
    return (b && v != MAX) ? v + 1'b1 : v;
  endfunction
  always_comb begin
    start = state == IDLE && s.in_tvalid;
    fin = state == ACTIVE && s.out_tvalid && s.out_tlast;
    push = fin || to;
    pop = s.stat_tvalid && s.stat_tready;
    full = cnt == (AW+1)'(DEPTH);
    push_ok = push && (!full || pop);
    cnt_n = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    n_total = sat(total, 1'b1);
    n_stalled = sat(stalled, s.in_tvalid && !s.in_tready);
    n_beats = sat(beats, s.in_tvalid && s.in_tready);
    n_ovalid = sat(ovalid, s.out_tvalid);
  end
`ifdef CCSDS123_MON_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  // wd counts consecutive cycles without out_tvalid, the start cycle included
  assign to = state == ACTIVE && !s.out_tvalid && wd == WW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || push) wd <= '0;
    else if (start) wd <= WW'(!s.out_tvalid);
    else if (state == ACTIVE) wd <= s.out_tvalid ? '0 : wd + 1'b1;
  end
`else
  assign to = 1'b0;
`endif
  assign s.stat_tdata = s.stat_tvalid ? mem[rd] : '0;
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr] <= {to, idx, n_total, n_stalled, n_beats, n_ovalid};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      dropped <= 1'b0;
      total <= '0;
      stalled <= '0;
      beats <= '0;
      ovalid <= '0;
      idx <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      s.stat_tvalid <= 1'b0;
    end else begin
      if (start || state == ACTIVE) begin
        total <= push ? '0 : n_total;
        stalled <= push ? '0 : n_stalled;
        beats <= push ? '0 : n_beats;
        ovalid <= push ? '0 : n_ovalid;
      end
      if (start) begin
        state <= ACTIVE;
        busy <= 1'b1;
      end else if (push) begin
        state <= IDLE;
        busy <= 1'b0;
      end
      if (push) idx <= idx + 1'b1;
      if (push_ok) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (push && !push_ok) dropped <= 1'b1;
      cnt <= cnt_n;
      s.stat_tvalid <= cnt_n != '0;
    end
  end
endmodule

// File: tb/tb_ccsds123_stream_monitor.sv
// tb_ccsds123_stream_monitor: directed frame table, corner sequences and random traffic against a frame-level model
module tb_ccsds123_stream_monitor;
`ifdef CCSDS123_MON_WATCHDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic busy, dropped, busy_s, dropped_s;
  logic srdy = 0;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  ccsds123_stream_monitor_if #(.CNT_W(32), .IDX_W(16)) i1();
  ccsds123_stream_monitor_if #(.CNT_W(4), .IDX_W(16)) i2();
  assign i2.in_tvalid = i1.in_tvalid;
  assign i2.in_tready = i1.in_tready;
  assign i2.out_tvalid = i1.out_tvalid;
  assign i2.out_tlast = i1.out_tlast;
  assign i2.stat_tready = i1.stat_tready;

  ccsds123_stream_monitor #(.CNT_W(32), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s(i1), .busy(busy), .dropped(dropped));
  ccsds123_stream_monitor #(.CNT_W(4), .DEPTH(DEPTH), .TIMEOUT(TO)) dut_s (
    .clk(clk), .rst(rst), .s(i2), .busy(busy_s), .dropped(dropped_s));

  typedef struct {bit to; int idx; int tot; int st; int bt; int ov;} rec_t;
  rec_t q[$];
  bit m_active = 0, m_drop = 0;
  int m_idx = 0, m_gap = 0;
  rec_t cur;

  function automatic logic [3:0] s4(int x);
    return x > 15 ? 4'hf : 4'(x);
  endfunction
  function automatic logic [144:0] pack(rec_t r);
    return {r.to, 16'(r.idx), 32'(r.tot), 32'(r.st), 32'(r.bt), 32'(r.ov)};
  endfunction
  function automatic logic [32:0] pack_s(rec_t r);
    return {r.to, 16'(r.idx), s4(r.tot), s4(r.st), s4(r.bt), s4(r.ov)};
  endfunction

  task automatic chk(string name, logic [144:0] act, logic [144:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // frame-level reference: accumulate plain integer counts, emit a record at frame end
  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_drop = 0; m_idx = 0; m_gap = 0; q.delete();
    end else begin
      bit pop, done, tmo;
      int iv, ir, ov;
      iv = int'(i1.in_tvalid); ir = int'(i1.in_tready); ov = int'(i1.out_tvalid);
      pop = q.size() > 0 && i1.stat_tready;
      done = 0; tmo = 0;
      if (!m_active) begin
        if (iv == 1) begin
          m_active = 1;
          cur = '{0, m_idx, 1, iv & (1 - ir), iv & ir, ov};
          m_gap = ov ? 0 : 1;
        end
      end else begin
        cur.tot++; cur.st += iv & (1 - ir); cur.bt += iv & ir; cur.ov += ov;
        m_gap = ov ? 0 : m_gap + 1;
        if (ov == 1 && i1.out_tlast) done = 1;
`ifdef CCSDS123_MON_WATCHDOG_EN
        else if (m_gap >= TO) tmo = 1;
`endif
      end
      if (pop) void'(q.pop_front());
      if (done || tmo) begin
        cur.to = tmo;
        if (q.size() < DEPTH) q.push_back(cur);
        else m_drop = 1;
        m_idx = (m_idx + 1) % 65536;
        m_active = 0;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", 145'(busy), 145'(m_active));
    chk("busy_small", 145'(busy_s), 145'(m_active));
    chk("dropped", 145'(dropped), 145'(m_drop));
    chk("stat_tvalid", 145'(i1.stat_tvalid), 145'(q.size() != 0));
    if (q.size() != 0) begin
      chk("stat_tdata", i1.stat_tdata, pack(q[0]));
      chk("stat_tdata_small", 145'(i2.stat_tdata), 145'(pack_s(q[0])));
    end
  end

  task automatic step(bit iv, bit ir, bit ov, bit ol);
    i1.in_tvalid = iv; i1.in_tready = ir; i1.out_tvalid = ov; i1.out_tlast = ol;
    i1.stat_tready = srdy;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1; step(0, 0, 0, 0); step(0, 0, 0, 0); rst = 0;
  endtask
  // cycle c of len: first ns valid cycles stalled, then nb accepted; last nov cycles carry out_tvalid
  task automatic run_frame(int len, int nb, int ns, int nov);
    for (int c = 1; c <= len; c++)
      step(c <= nb + ns, c > ns, c > len - nov, c == len);
  endtask
  task automatic pop_one();
    srdy = 1; step(0, 0, 0, 0); srdy = 0;
  endtask

  typedef struct {int len, nb, ns, nov, e_tot, e_st, e_bt, e_ov, e_stot;} vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{20, 8, 0, 3, 20, 0, 8, 3, 15};
    tbl[1] = '{25, 8, 5, 3, 25, 5, 8, 3, 15};
    tbl[2] = '{3, 1, 0, 1, 3, 0, 1, 1, 3};
    tbl[3] = '{2, 2, 0, 1, 2, 0, 2, 1, 2};
    tbl[4] = '{12, 0, 4, 12, 12, 4, 0, 12, 12};
    i1.in_tvalid = 0; i1.in_tready = 0; i1.out_tvalid = 0; i1.out_tlast = 0; i1.stat_tready = 0;
    do_reset();
    chk_en = 1;
    chk("reset_tvalid", 145'(i1.stat_tvalid), 145'(0));
    chk("reset_tdata", i1.stat_tdata, 145'(0));
    chk("reset_busy", 145'(busy), 145'(0));
    chk("reset_dropped", 145'(dropped), 145'(0));
    foreach (tbl[i]) begin
      run_frame(tbl[i].len, tbl[i].nb, tbl[i].ns, tbl[i].nov);
      chk("tbl_tvalid_end1", 145'(i1.stat_tvalid), 145'(1));
      chk("tbl_record", i1.stat_tdata,
          {1'b0, 16'(i), 32'(tbl[i].e_tot), 32'(tbl[i].e_st), 32'(tbl[i].e_bt), 32'(tbl[i].e_ov)});
      chk("tbl_small_total", 145'(i2.stat_tdata[15:12]), 145'(tbl[i].e_stot));
      pop_one();
      chk("tbl_drained", 145'(i1.stat_tvalid), 145'(0));
    end
    do_reset();
    for (int f = 0; f <= DEPTH; f++) begin
      run_frame(3, 1, 0, 1);
      step(0, 0, 0, 0);
    end
    chk("overflow_dropped", 145'(dropped), 145'(1));
    for (int k = 0; k < DEPTH; k++) begin
      chk("overflow_tvalid", 145'(i1.stat_tvalid), 145'(1));
      chk("overflow_idx", 145'(i1.stat_tdata[143:128]), 145'(k));
      pop_one();
    end
    chk("overflow_empty", 145'(i1.stat_tvalid), 145'(0));
    run_frame(3, 1, 0, 1);
    chk("overflow_next_idx", 145'(i1.stat_tdata[143:128]), 145'(DEPTH + 1));
    pop_one();
    run_frame(3, 1, 0, 1);
    for (int c = 0; c < 10; c++) step(1, 1, 0, 0);
    chk("midrst_busy_before", 145'(busy), 145'(1));
    rst = 1; step(0, 0, 0, 0); rst = 0;
    chk("midrst_busy", 145'(busy), 145'(0));
    chk("midrst_tvalid", 145'(i1.stat_tvalid), 145'(0));
    chk("midrst_dropped", 145'(dropped), 145'(0));
    step(0, 0, 0, 0);
    chk("midrst_no_partial", 145'(i1.stat_tvalid), 145'(0));
    run_frame(3, 1, 0, 1);
    chk("midrst_idx0", 145'(i1.stat_tdata[143:128]), 145'(0));
    pop_one();
    step(1, 1, 0, 1);
    chk("idle_tlast_ignored", 145'(busy), 145'(1));
    step(0, 0, 1, 1);
    chk("idle_tlast_end", 145'(i1.stat_tdata[127:96]), 145'(2));
    pop_one();
`ifdef CCSDS123_MON_WATCHDOG_EN
    do_reset();
    step(1, 1, 0, 0);
    for (int c = 0; c < 20; c++) step(0, 0, 0, 0);
    chk("wd_busy", 145'(busy), 145'(0));
    chk("wd_timeout", 145'(i1.stat_tdata[144]), 145'(1));
    chk("wd_total", 145'(i1.stat_tdata[127:96]), 145'(16));
    pop_one();
`endif
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      srdy = ($urandom_range(0, 99) < 50);
      rst = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 12);
    end
    rst = 0; srdy = 0;
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
